// File: rtl/count_event_monitor_pkg.sv
// Shared types for the counter event monitor.
// Event codes, queue payload and counter width.
package count_mon_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    EVT_WRAP_UP  = 2'd0,
    EVT_WRAP_DN  = 2'd1,
    EVT_CROSS_UP = 2'd2,
    EVT_CROSS_DN = 2'd3
  } evt_e;

  typedef struct packed {
    evt_e             code;
    logic [CNT_W-1:0] count;
  } evt_t;

endpackage

// File: rtl/count_evt_fifo.sv
// First-word fall-through event queue, DEPTH entries.
// Ports: clk, reset, push/push_data, pop, pop_data, full, empty, level, drop.
module count_evt_fifo
  import count_mon_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = evt_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          drop
);

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  T              mem_q [DEPTH];
  T              mem_d [DEPTH];

  logic do_pop;
  logic do_push;

  assign full  = (lvl_q == LW'(DEPTH));
  assign empty = (lvl_q == '0);
  assign level = lvl_q;

  // A full queue still takes a push when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_comb begin
    pop_data = '0;
    if (!empty) begin
      pop_data = mem_q[rd_q];
    end
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    lvl_d = lvl_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/count_event_monitor.sv
// Observer of the 8-bit up/down counter: wrap/cross events, wrap tally,
// drop tally, sticky step error. Ports: clk, reset, cnt_* in, evt_* queue.
module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              cnt_out,
  input  logic                    cnt_up_down,
  input  logic                    cnt_reset,
  input  logic [7:0]              threshold,
  input  logic                    evt_ready,
  output logic                    evt_valid,
  output logic [1:0]              evt_code,
  output logic [7:0]              evt_count,
  output logic [15:0]             wrap_cnt,
  output logic [7:0]              drop_cnt,
  output logic                    step_err,
  output logic [$clog2(DEPTH):0]  level
);

  logic [CNT_W-1:0] prev_cnt_q, prev_cnt_d;
  logic             prev_ud_q, prev_ud_d;
  logic             prev_rst_q, prev_rst_d;
  logic             prev_vld_q, prev_vld_d;
  logic             step_err_q, step_err_d;
  logic [15:0]      wrap_cnt_q, wrap_cnt_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] exp_cnt;
  logic             wrap_up, wrap_dn, cross_up, cross_dn;
  logic             evt_hit;
  evt_t             evt_new;
  evt_t             head;
  logic             q_full, q_empty, q_drop;

  always_comb begin
    exp_cnt  = '0;
    if (!prev_rst_q) begin
      exp_cnt = prev_ud_q ? prev_cnt_q + 8'd1 : prev_cnt_q - 8'd1;
    end
    // A counter reset from 255 lands on 0 but is not a wrap.
    wrap_up  = (prev_cnt_q == 8'hFF) && (cnt_out == 8'h00) && !prev_rst_q;
    wrap_dn  = (prev_cnt_q == 8'h00) && (cnt_out == 8'hFF);
    cross_up = (prev_cnt_q < threshold) && (threshold <= cnt_out);
    cross_dn = (cnt_out < threshold) && (threshold <= prev_cnt_q);

    evt_hit       = 1'b0;
    evt_new.code  = EVT_WRAP_UP;
    evt_new.count = cnt_out;
    if (prev_vld_q) begin
      priority case (1'b1)
        wrap_up: begin
          evt_hit      = 1'b1;
          evt_new.code = EVT_WRAP_UP;
        end
        wrap_dn: begin
          evt_hit      = 1'b1;
          evt_new.code = EVT_WRAP_DN;
        end
        cross_up: begin
          evt_hit      = 1'b1;
          evt_new.code = EVT_CROSS_UP;
        end
        cross_dn: begin
          evt_hit      = 1'b1;
          evt_new.code = EVT_CROSS_DN;
        end
        default: evt_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    prev_cnt_d = cnt_out;
    prev_ud_d  = cnt_up_down;
    prev_rst_d = cnt_reset;
    prev_vld_d = 1'b1;
    step_err_d = step_err_q;
    wrap_cnt_d = wrap_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (prev_vld_q && (cnt_out != exp_cnt)) begin
      step_err_d = 1'b1;
    end
    if (prev_vld_q && (wrap_up || wrap_dn) && (wrap_cnt_q != 16'hFFFF)) begin
      wrap_cnt_d = wrap_cnt_q + 16'd1;
    end
    if (q_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cnt_q <= '0;
      prev_ud_q  <= 1'b0;
      prev_rst_q <= 1'b0;
      prev_vld_q <= 1'b0;
      step_err_q <= 1'b0;
      wrap_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      prev_cnt_q <= prev_cnt_d;
      prev_ud_q  <= prev_ud_d;
      prev_rst_q <= prev_rst_d;
      prev_vld_q <= prev_vld_d;
      step_err_q <= step_err_d;
      wrap_cnt_q <= wrap_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  count_evt_fifo #(
    .DEPTH (DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (evt_hit),
    .push_data (evt_new),
    .pop       (evt_ready),
    .pop_data  (head),
    .full      (q_full),
    .empty     (q_empty),
    .level     (level),
    .drop      (q_drop)
  );

  assign evt_valid = !q_empty;
  assign evt_code  = head.code;
  assign evt_count = head.count;
  assign wrap_cnt  = wrap_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign step_err  = step_err_q;

endmodule

// File: doc/count_event_monitor.md
# count_event_monitor

Downstream observer of the 8-bit up/down counter. Each cycle it samples the counter output plus the counter's own control inputs (`up_down`, `reset`). From these it reports:
- wrap-around and threshold-crossing events through a 4-deep valid/ready event queue;
- a saturating wrap tally;
- a sticky step-error flag for any count transition the counter's rules do not allow.

## Interface
- `DEPTH`, 4, event queue entries (power of two, ≥2)
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `cnt_out`  in  8  counter output, sampled every edge
- `cnt_up_down`  in  1  the `up_down` value presented to the counter this cycle
- `cnt_reset`  in  1  the reset value presented to the counter this cycle
- `threshold`  in  8  crossing threshold, compared every cycle
- `evt_ready`  in  1  consumer accepts the head event
- `evt_valid`  out  1  queue non-empty
- `evt_code`  out  2  head event type (`evt_e`)
- `evt_count`  out  8  `cnt_out` value at detection
- `wrap_cnt`  out  16  wraps seen, saturates at 0xFFFF
- `drop_cnt`  out  8  events lost to full queue, saturates at 0xFF
- `step_err`  out  1  sticky illegal-transition flag
- `level`  out  3  current queue occupancy, 0..`DEPTH`

## Operation
- **Registered history.** `prev_cnt`, `prev_ud`, `prev_rst` and `prev_vld` capture `cnt_out`, `cnt_up_down` and `cnt_reset` every edge. `prev_vld` is 0 after reset and becomes 1 at the first edge after reset deasserts.
- **Comparisons.** Only performed when `prev_vld` = 1; `prev` = `prev_cnt`, `cur` = `cnt_out`.
- **Expected value.**
  - 0 if `prev_rst`;
  - otherwise `prev` + 1 if `prev_ud`, else `prev` − 1, both mod 256.
- **Step error.** `cur` ≠ expected sets `step_err`. It stays set until `reset`. No event is generated for a step error.
- **Event detection.** At most one event per cycle, checked in this priority order:
  - `EVT_WRAP_UP`: `prev` = 255, `cur` = 0, `!prev_rst`.
  - `EVT_WRAP_DN`: `prev` = 0, `cur` = 255.
  - `EVT_CROSS_UP`: `prev` < `threshold` ≤ `cur`.
  - `EVT_CROSS_DN`: `cur` < `threshold` ≤ `prev`.
  - All comparisons are unsigned and use the current `threshold` for both sides.
  - A counter reset (255→0 with `prev_rst`) is not a wrap. It can still produce `EVT_CROSS_DN`.
- **Wrap tally.** `wrap_cnt` increments on either wrap event, whether or not the event is queued.
- **Queue.** Synchronous FIFO, first-word fall-through: head `{evt_code, evt_count}` is valid whenever `evt_valid` = 1.
  - **Pop:** `evt_valid && evt_ready`.
  - **Push:** an event was detected.
  - **Full, push and pop in the same cycle:** the push is accepted and `level` is unchanged.
  - **Full, push without pop:** the event is discarded and `drop_cnt` increments (saturating).
  - **Empty, push:** no bypass; `evt_valid` rises on the next edge.
- **Head stability.** Head fields are stable while `evt_valid && !evt_ready`.
- **Reset.** Synchronous. Applies to all outputs and is honoured mid-operation, including with a queue holding events.
  - `evt_valid` = 0, `evt_code` = 0, `evt_count` = 0;
  - `wrap_cnt` = 0, `drop_cnt` = 0, `step_err` = 0, `level` = 0;
  - queue pointers cleared, contents discarded, `prev_*` = 0.

## Timing
- Edge k samples `cnt_out`; detection is combinational against `prev_*` from edge k−1.
- The push occurs at edge k. `evt_valid`, `level`, `wrap_cnt` and `step_err` reflect it after edge k, i.e. one cycle after the counter shows the new value.
- Pop latency: the head advances at the edge where `evt_valid && evt_ready`. The next entry is presented in the following cycle.
- Throughput: one push and one pop per cycle.
- No combinational path from `evt_ready` to any output.
- The first edge after reset deassert produces no event and no step check.

## Structure
- **Package `count_mon_pkg`:**
  - `typedef enum logic [1:0] evt_e {EVT_WRAP_UP=0, EVT_WRAP_DN=1, EVT_CROSS_UP=2, EVT_CROSS_DN=3}`;
  - `typedef struct packed {evt_e code; logic [7:0] count;} evt_t`;
  - `localparam CNT_W = 8`.
- **Sub-module `count_evt_fifo`:** parameterised on `DEPTH` and payload type `evt_t`. It has push/pop/full/empty/level and contains the full-with-simultaneous-pop rule.
- **Top level `count_event_monitor`:** history registers, detection/priority logic, step checker, and the saturating counters.

## Test plan
- **Counting up, threshold 0x80, `evt_ready` = 1:**
  - reset, then count 0x7E→0x81 up → one `EVT_CROSS_UP`, `evt_count` = 0x80, `evt_valid` one cycle after `cnt_out` = 0x80;
  - continue 0xFE→0x01 → one `EVT_WRAP_UP`, count 0x00, `wrap_cnt` = 1;
  - `step_err` stays 0 throughout.
- **Counting down from 0x01, threshold 0x80:** 0x01→0xFE → `EVT_WRAP_DN`, count 0xFF (not `EVT_CROSS_UP`). `wrap_cnt` increments.
- **Counter reset from 0xFF, threshold 0x10:** assert `cnt_reset` at 0xFF → no wrap event, `EVT_CROSS_DN` with count 0x00, `wrap_cnt` unchanged, `step_err` 0.
- **Overflow with `evt_ready` = 0:** generate 6 events → `level` = 4, `drop_cnt` = 2. Raise `evt_ready` → drains in FIFO order, one per cycle.
- **Full queue with simultaneous push and pop:** push and pop in the same cycle → `level` stays 4, `drop_cnt` unchanged, new event appears last.
- **Illegal jump and mid-operation reset:**
  - force 0x10→0x20 → `step_err` = 1 the next cycle and stays set;
  - assert `reset` with 3 queued events → next cycle all outputs are 0;
  - first post-reset sample raises no event.
